// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - press sequencer for the switch-accumulate datapath
// Debounces the Run_Accumulate button and issues one register-load per press.
module accum_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2,
  parameter int CNT_W           = 8
) (
  input  logic             Clk,
  input  logic             Reset_Clear,
  input  logic             Run_Accumulate,
  input  logic             Clear_Acc,
  input  logic             Carry_In,
  output logic             Reg_Load,
  output logic             Reg_Clear,
  output logic             Busy,
  output logic             Overflow,
  output logic [CNT_W-1:0] Acc_Count
);

  localparam int MAX_CYC = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [TW-1:0] DEB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DEBOUNCE, S_SETTLE, S_LOAD, S_HOLD, S_CLEAR
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_run_s;
  logic [TW-1:0]          r_cnt;
  logic                   r_overflow;
  logic [CNT_W-1:0]       r_count;

  // Synchroniser carries the pressed sense (1 = pressed) so cleared flops mean released.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      r_sync  <= '0;
      r_run_s <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], ~Run_Accumulate};
      r_run_s <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Clear_Acc)    w_next = S_CLEAR;
        else if (r_run_s) w_next = S_DEBOUNCE;
      end
      S_DEBOUNCE: begin
        if (!r_run_s)               w_next = S_IDLE;
        else if (r_cnt == DEB_LAST) w_next = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == SET_LAST) w_next = S_LOAD;
      end
      S_LOAD:  w_next = S_HOLD;
      S_HOLD: begin
        if (!r_run_s && (r_cnt == DEB_LAST)) w_next = S_IDLE;
      end
      S_CLEAR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    Reg_Load  = 1'b0;
    Reg_Clear = 1'b0;
    Busy      = 1'b1;
    case (r_state)
      S_IDLE:  Busy      = 1'b0;
      S_LOAD:  Reg_Load  = 1'b1;
      S_CLEAR: Reg_Clear = 1'b1;
      default: Busy      = 1'b1;
    endcase
  end

  // One shared counter: stable-press cycles, settle cycles, or released cycles in HOLD.
  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        S_DEBOUNCE: begin
          if (!r_run_s || (r_cnt == DEB_LAST)) r_cnt <= '0;
          else                                 r_cnt <= r_cnt + 1'b1;
        end
        S_SETTLE: begin
          if (r_cnt == SET_LAST) r_cnt <= '0;
          else                   r_cnt <= r_cnt + 1'b1;
        end
        S_HOLD: begin
          if (r_run_s || (r_cnt == DEB_LAST)) r_cnt <= '0;
          else                                r_cnt <= r_cnt + 1'b1;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      r_overflow <= 1'b0;
      r_count    <= '0;
    end else if (r_state == S_LOAD) begin
      r_overflow <= r_overflow | Carry_In;
      if (r_count != '1) r_count <= r_count + 1'b1;
    end else if (r_state == S_CLEAR) begin
      r_overflow <= 1'b0;
      r_count    <= '0;
    end
  end

  assign Overflow  = r_overflow;
  assign Acc_Count = r_count;

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - self-checking bench for accum_sequencer
// Timestamp-based behavioural model plus directed scenarios with literal expectations.
module tb_accum_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int SET  = 2;
  localparam int DLY  = SYNC + 1;

  localparam int M_IDLE = 0, M_ARM = 1, M_WAIT = 2, M_LOAD = 3, M_HOLD = 4, M_CLR = 5;

  logic       Clk, Reset_Clear, Run_Accumulate, Clear_Acc, Carry_In;
  logic       Reg_Load, Reg_Clear, Busy, Overflow;
  logic [7:0] Acc_Count;
  logic       s_load, s_clear, s_busy, s_ovf;
  logic [1:0] s_count;

  accum_sequencer dut (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate),
    .Clear_Acc(Clear_Acc), .Carry_In(Carry_In), .Reg_Load(Reg_Load),
    .Reg_Clear(Reg_Clear), .Busy(Busy), .Overflow(Overflow), .Acc_Count(Acc_Count)
  );

  accum_sequencer #(.CNT_W(2)) dut_s (
    .Clk(Clk), .Reset_Clear(Reset_Clear), .Run_Accumulate(Run_Accumulate),
    .Clear_Acc(Clear_Acc), .Carry_In(Carry_In), .Reg_Load(s_load),
    .Reg_Clear(s_clear), .Busy(s_busy), .Overflow(s_ovf), .Acc_Count(s_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  int m_mode, m_edge, m_armed, m_load_at, m_low, m_cnt;
  bit m_ovf, m_run;
  bit m_hist [DLY];

  int load_pulses, clear_pulses, last_load_edge, busy_fall_edge, first_clear_edge;
  bit prev_busy;
  int e0, er;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at edge %0d", name, act, exp, edge_n);
    end
  endtask

  function automatic void m_reset();
    m_mode = M_IDLE;
    m_low  = 0;
    m_cnt  = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < DLY; i++) m_hist[i] = 1'b0;
  endfunction

  always @(posedge Clk) edge_n++;

  // run_s seen at edge n is the press state sampled at edge n-DLY.
  always @(posedge Clk or negedge Reset_Clear) begin
    if (!Reset_Clear) begin
      m_reset();
    end else begin
      m_run = m_hist[DLY-1];
      for (int i = DLY - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = !Run_Accumulate;
      m_edge++;
      case (m_mode)
        M_IDLE: begin
          if (Clear_Acc) m_mode = M_CLR;
          else if (m_run) begin
            m_mode  = M_ARM;
            m_armed = m_edge;
          end
        end
        M_ARM: begin
          if (!m_run) m_mode = M_IDLE;
          else if (m_edge == m_armed + DEB) begin
            m_mode    = M_WAIT;
            m_load_at = m_edge + SET;
          end
        end
        M_WAIT: if (m_edge == m_load_at) m_mode = M_LOAD;
        M_LOAD: begin
          m_cnt++;
          m_ovf  = m_ovf | Carry_In;
          m_low  = 0;
          m_mode = M_HOLD;
        end
        M_HOLD: begin
          m_low = m_run ? 0 : m_low + 1;
          if (m_low == DEB) m_mode = M_IDLE;
        end
        default: begin
          m_cnt  = 0;
          m_ovf  = 1'b0;
          m_mode = M_IDLE;
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (Reset_Clear) begin
      chk("reg_load",  Reg_Load,  m_mode == M_LOAD);
      chk("reg_clear", Reg_Clear, m_mode == M_CLR);
      chk("busy",      Busy,      m_mode != M_IDLE);
      chk("overflow",  Overflow,  m_ovf);
      chk("acc_count", Acc_Count, (m_cnt > 255) ? 255 : m_cnt);
      chk("sat_count", s_count,   (m_cnt > 3) ? 3 : m_cnt);
      chk("load_clear_excl", Reg_Load & Reg_Clear, 0);
      if (Reg_Load) begin
        load_pulses++;
        last_load_edge = edge_n;
      end
      if (Reg_Clear) begin
        clear_pulses++;
        if (first_clear_edge < 0) first_clear_edge = edge_n;
      end
      if (prev_busy && !Busy) busy_fall_edge = edge_n;
      prev_busy = Busy;
    end
  end

  task automatic press(input int n);
    Run_Accumulate = 1'b0;
    e0 = edge_n + 1;
    repeat (n) @(negedge Clk);
    Run_Accumulate = 1'b1;
    er = edge_n + 1;
  endtask

  initial begin
    m_reset();
    m_edge = 0;
    prev_busy = 1'b0;
    load_pulses = 0; clear_pulses = 0;
    last_load_edge = -1; busy_fall_edge = -1; first_clear_edge = -1;
    Reset_Clear = 1'b0; Run_Accumulate = 1'b1; Clear_Acc = 1'b0; Carry_In = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_load", Reg_Load, 0);
    chk("rst_clear", Reg_Clear, 0);
    chk("rst_ovf", Overflow, 0);
    chk("rst_count", Acc_Count, 0);
    @(negedge Clk);
    Reset_Clear = 1'b1;
    repeat (2) @(negedge Clk);

    // 1: clean press
    load_pulses = 0;
    press(30);
    repeat (12) @(negedge Clk);
    #1;
    chk("t1_load_latency", last_load_edge - e0, 9);
    chk("t1_pulses", load_pulses, 1);
    chk("t1_count", Acc_Count, 1);
    chk("t1_busy_fall", busy_fall_edge - er, SYNC + DEB);

    // 2: glitch
    load_pulses = 0;
    press(3);
    repeat (12) @(negedge Clk);
    #1;
    chk("t2_pulses", load_pulses, 0);
    chk("t2_count", Acc_Count, 1);
    chk("t2_busy", Busy, 0);

    // 3: overflow then soft clear
    Carry_In = 1'b1;
    press(20);
    repeat (10) @(negedge Clk);
    #1;
    chk("t3_ovf_set", Overflow, 1);
    chk("t3_count2", Acc_Count, 2);
    Carry_In = 1'b0;
    press(20);
    repeat (10) @(negedge Clk);
    #1;
    chk("t3_ovf_sticky", Overflow, 1);
    chk("t3_count3", Acc_Count, 3);
    clear_pulses = 0;
    Clear_Acc = 1'b1;
    @(negedge Clk);
    Clear_Acc = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("t3_clear_pulses", clear_pulses, 1);
    chk("t3_ovf_cleared", Overflow, 0);
    chk("t3_count_cleared", Acc_Count, 0);

    // 4: clear raised during HOLD is deferred
    clear_pulses = 0;
    first_clear_edge = -1;
    Run_Accumulate = 1'b0;
    repeat (14) @(negedge Clk);
    Clear_Acc = 1'b1;
    repeat (6) @(negedge Clk);
    chk("t4_no_early_clear", clear_pulses, 0);
    Run_Accumulate = 1'b1;
    er = edge_n + 1;
    repeat (10) @(negedge Clk);
    Clear_Acc = 1'b0;
    repeat (3) @(negedge Clk);
    #1;
    chk("t4_clear_edge", first_clear_edge - er, SYNC + DEB + 1);
    chk("t4_count", Acc_Count, 0);

    // 5: saturation on the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      press(12);
      repeat (10) @(negedge Clk);
      #1;
      chk($sformatf("t5_sat_%0d", i), s_count, sat_exp[i]);
    end
    chk("t5_wide_count", Acc_Count, 5);

    // 6: asynchronous reset while settling
    Run_Accumulate = 1'b0;
    e0 = edge_n + 1;
    repeat (8) @(negedge Clk);
    #1;
    chk("t6_busy_before", Busy, 1);
    Reset_Clear = 1'b0;
    #1;
    chk("t6_rst_busy", Busy, 0);
    chk("t6_rst_load", Reg_Load, 0);
    chk("t6_rst_clear", Reg_Clear, 0);
    chk("t6_rst_count", Acc_Count, 0);
    chk("t6_rst_ovf", Overflow, 0);
    @(negedge Clk);
    Run_Accumulate = 1'b1;
    @(negedge Clk);
    Reset_Clear = 1'b1;
    repeat (2) @(negedge Clk);
    load_pulses = 0;
    last_load_edge = -1;
    press(30);
    repeat (12) @(negedge Clk);
    #1;
    chk("t6_load_latency", last_load_edge - e0, 9);
    chk("t6_pulses", load_pulses, 1);
    chk("t6_count", Acc_Count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
